// File: rtl/alu_accum_pkg.sv
// Shared opcode encoding, flag bit positions and overflow helpers for alu_accum.
package alu_accum_pkg;

  typedef enum logic [2:0] {
    OP_ADD     = 3'b000,
    OP_SUB     = 3'b001,
    OP_AND     = 3'b010,
    OP_OR      = 3'b011,
    OP_XOR     = 3'b100,
    OP_ACC_ADD = 3'b101,
    OP_ACC_CLR = 3'b110,
    OP_RSVD    = 3'b111
  } op_e;

  // Bit positions inside the 4-bit {V, C, N, Z} flag vector.
  localparam int FLAG_V = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  // Signed overflow of an addition: same-sign operands giving a different-sign result.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

  // Signed overflow of a subtraction: opposite-sign operands, result sign differs from minuend.
  function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb != b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/alu_accum_core.sv
// Combinational datapath: arithmetic/logic ops, optional unsigned saturation,
// flag generation and the next accumulator value.
module alu_accum_core
  import alu_accum_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int SATURATE = 0
) (
  input  op_e              i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_acc,
  output logic [WIDTH:0]   o_result,
  output logic [3:0]       o_flags,
  output logic             o_err,
  output logic             o_acc_wr,
  output logic [WIDTH-1:0] o_acc_next
);

  localparam logic [WIDTH:0] SAT_VAL = {(WIDTH+1){1'b1}};

  logic [WIDTH:0] w_sum_ab;
  logic [WIDTH:0] w_dif_ab;
  logic [WIDTH:0] w_sum_acc;
  logic           w_ovf;

  // Widened by one bit so the MSB carries the carry (add) or borrow (sub).
  assign w_sum_ab  = {1'b0, i_a}   + {1'b0, i_b};
  assign w_dif_ab  = {1'b0, i_a}   - {1'b0, i_b};
  assign w_sum_acc = {1'b0, i_acc} + {1'b0, i_a};

  // Operation select; saturation replaces a carried sum with all-ones.
  always_comb begin
    o_result   = {(WIDTH+1){1'b0}};
    w_ovf      = 1'b0;
    o_err      = 1'b0;
    o_acc_wr   = 1'b0;
    o_acc_next = i_acc;
    case (i_op)
      OP_ADD: begin
        o_result = ((SATURATE != 0) && w_sum_ab[WIDTH]) ? SAT_VAL : w_sum_ab;
        w_ovf    = add_ovf(i_a[WIDTH-1], i_b[WIDTH-1], w_sum_ab[WIDTH-1]);
      end
      OP_SUB: begin
        o_result = w_dif_ab;
        w_ovf    = sub_ovf(i_a[WIDTH-1], i_b[WIDTH-1], w_dif_ab[WIDTH-1]);
      end
      OP_AND: o_result = {1'b0, i_a & i_b};
      OP_OR:  o_result = {1'b0, i_a | i_b};
      OP_XOR: o_result = {1'b0, i_a ^ i_b};
      OP_ACC_ADD: begin
        o_result   = ((SATURATE != 0) && w_sum_acc[WIDTH]) ? SAT_VAL : w_sum_acc;
        w_ovf      = add_ovf(i_acc[WIDTH-1], i_a[WIDTH-1], w_sum_acc[WIDTH-1]);
        o_acc_wr   = 1'b1;
        o_acc_next = o_result[WIDTH-1:0];
      end
      OP_ACC_CLR: begin
        o_result   = {(WIDTH+1){1'b0}};
        o_acc_wr   = 1'b1;
        o_acc_next = {WIDTH{1'b0}};
      end
      OP_RSVD: o_err = 1'b1;
      default: o_err = 1'b1;
    endcase
  end

  // Flags follow the selected result; the reserved opcode reports all-zero flags.
  always_comb begin
    o_flags = 4'b0000;
    if (o_err) begin
      o_flags = 4'b0000;
    end else begin
      o_flags[FLAG_V] = w_ovf;
      o_flags[FLAG_C] = o_result[WIDTH];
      o_flags[FLAG_N] = o_result[WIDTH-1];
      o_flags[FLAG_Z] = (o_result[WIDTH-1:0] == {WIDTH{1'b0}});
    end
  end

endmodule

// File: rtl/alu_accum.sv
// Two-stage valid/ready ALU with accumulator: S1 holds the request, S2 holds the
// computed result. The accumulator is updated as S2 loads, so a following ACC op
// in S1 already sees the new value without a bubble.
module alu_accum
  import alu_accum_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   result,
  output logic [3:0]       flags,
  output logic             err,
  output logic [WIDTH-1:0] acc_value
);

  logic             r_s1_valid;
  op_e              r_s1_op;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic             r_s2_valid;
  logic [WIDTH:0]   r_result;
  logic [3:0]       r_flags;
  logic             r_err;
  logic [WIDTH-1:0] r_acc;

  logic             w_s2_load;
  logic             w_s1_load;
  logic [WIDTH:0]   w_result;
  logic [3:0]       w_flags;
  logic             w_err;
  logic             w_acc_wr;
  logic [WIDTH-1:0] w_acc_next;

  // S2 takes S1 when it is empty or its result leaves this cycle; S1 refills as it drains.
  assign w_s2_load = r_s1_valid && (!r_s2_valid || out_ready);
  assign w_s1_load = !r_s1_valid || w_s2_load;

  assign in_ready  = w_s1_load;
  assign out_valid = r_s2_valid;
  assign result    = r_result;
  assign flags     = r_flags;
  assign err       = r_err;
  assign acc_value = r_acc;

  alu_accum_core #(
    .WIDTH    (WIDTH),
    .SATURATE (SATURATE)
  ) u_core (
    .i_op       (r_s1_op),
    .i_a        (r_s1_a),
    .i_b        (r_s1_b),
    .i_acc      (r_acc),
    .o_result   (w_result),
    .o_flags    (w_flags),
    .o_err      (w_err),
    .o_acc_wr   (w_acc_wr),
    .o_acc_next (w_acc_next)
  );

  // Stage 1: capture the request whenever the stage is free or advancing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= OP_ADD;
      r_s1_a     <= {WIDTH{1'b0}};
      r_s1_b     <= {WIDTH{1'b0}};
    end else if (w_s1_load) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_op <= op_e'(op);
        r_s1_a  <= a;
        r_s1_b  <= b;
      end
    end
  end

  // Stage 2: register the computed result; hold it while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_result   <= {(WIDTH+1){1'b0}};
      r_flags    <= 4'b0000;
      r_err      <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_valid <= 1'b1;
      r_result   <= w_result;
      r_flags    <= w_flags;
      r_err      <= w_err;
    end else if (out_ready) begin
      r_s2_valid <= 1'b0;
    end
  end

  // Accumulator: written by ACC_ADD / ACC_CLR exactly when their result enters S2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= {WIDTH{1'b0}};
    end else if (w_s2_load && w_acc_wr) begin
      r_acc <= w_acc_next;
    end
  end

endmodule

// File: tb/tb_alu_accum.sv
// Scoreboard bench for alu_accum: directed vectors push hand-computed results,
// a monitor pops and compares on every output transfer and checks stall stability.
module tb_alu_accum;

  typedef struct packed {
    logic [8:0] res;
    logic [3:0] flg;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       sel_sat = 1'b0;
  logic [2:0] op = 3'b000;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       out_ready = 1'b1;
  int         rdy_mode = 0;

  logic       in_valid_m, in_valid_s, in_ready_m, in_ready_s;
  logic       out_valid_m, out_valid_s, err_m, err_s;
  logic [8:0] result_m, result_s;
  logic [3:0] flags_m, flags_s;
  logic [7:0] acc_m, acc_s;

  logic       ov   [2];
  logic [8:0] ores [2];
  logic [3:0] oflg [2];
  logic       oerr [2];

  exp_t q [2][$];
  int   n_chk  = 0;
  int   n_fail = 0;

  assign in_valid_m = in_valid && !sel_sat;
  assign in_valid_s = in_valid && sel_sat;
  assign ov[0] = out_valid_m;  assign ores[0] = result_m;  assign oflg[0] = flags_m;  assign oerr[0] = err_m;
  assign ov[1] = out_valid_s;  assign ores[1] = result_s;  assign oflg[1] = flags_s;  assign oerr[1] = err_s;

  alu_accum #(.WIDTH(8), .SATURATE(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_m), .in_ready(in_ready_m),
    .op(op), .a(a), .b(b), .out_valid(out_valid_m), .out_ready(out_ready),
    .result(result_m), .flags(flags_m), .err(err_m), .acc_value(acc_m)
  );

  alu_accum #(.WIDTH(8), .SATURATE(1)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s), .in_ready(in_ready_s),
    .op(op), .a(a), .b(b), .out_valid(out_valid_s), .out_ready(out_ready),
    .result(result_s), .flags(flags_s), .err(err_s), .acc_value(acc_s)
  );

  initial forever #5 clk = ~clk;

  // Consumer readiness: 0 = always ready, 1 = pattern 1,0,0,1 repeating, 2 = stalled.
  initial begin
    logic [3:0] pat;
    int         tog;
    pat = 4'b1001;
    tog = 0;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: begin out_ready = pat[tog]; tog = (tog + 1) % 4; end
        2: out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: compare each output transfer with the scoreboard; check holds during stalls.
  initial begin
    logic       prev_stall [2];
    logic [8:0] h_res [2];
    logic [3:0] h_flg [2];
    logic       h_err [2];
    exp_t       e;
    prev_stall[0] = 1'b0;
    prev_stall[1] = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      for (int d = 0; d < 2; d++) begin
        if (!rst_n) begin
          prev_stall[d] = 1'b0;
        end else begin
          if (prev_stall[d]) begin
            n_chk++;
            if (!ov[d] || ores[d] !== h_res[d] || oflg[d] !== h_flg[d] || oerr[d] !== h_err[d]) begin
              n_fail++;
              $display("FAIL stall_hold dut%0d: got valid=%b res=%h flags=%b err=%b, required valid=1 res=%h flags=%b err=%b",
                       d, ov[d], ores[d], oflg[d], oerr[d], h_res[d], h_flg[d], h_err[d]);
            end
          end
          if (ov[d] && out_ready) begin
            n_chk++;
            if (q[d].size() == 0) begin
              n_fail++;
              $display("FAIL unexpected_output dut%0d: got res=%h with no result outstanding, required none", d, ores[d]);
            end else begin
              e = q[d].pop_front();
              if (ores[d] !== e.res || oflg[d] !== e.flg || oerr[d] !== e.err) begin
                n_fail++;
                $display("FAIL result dut%0d: got res=%h flags=%b err=%b, required res=%h flags=%b err=%b",
                         d, ores[d], oflg[d], oerr[d], e.res, e.flg, e.err);
              end
            end
          end
          prev_stall[d] = ov[d] && !out_ready;
          h_res[d] = ores[d];
          h_flg[d] = oflg[d];
          h_err[d] = oerr[d];
        end
      end
    end
  end

  task automatic check(input string nm, input logic [15:0] got, input logic [15:0] req);
    n_chk++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, got, req);
    end
  endtask

  // Present one request at a negedge and hold it until accepted; record the expected result.
  task automatic send(input logic sel, input logic [2:0] o, input logic [7:0] av, input logic [7:0] bv,
                      input logic [8:0] er, input logic [3:0] ef, input logic ee);
    int   waited;
    exp_t e;
    @(negedge clk);
    sel_sat = sel;  in_valid = 1'b1;  op = o;  a = av;  b = bv;
    #1;
    waited = 0;
    while (!(sel ? in_ready_s : in_ready_m) && waited < 200) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (waited >= 200) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready=0 for 200 cycles, required 1");
      in_valid = 1'b0;
    end else begin
      e.res = er;  e.flg = ef;  e.err = ee;
      q[sel ? 1 : 0].push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Wait (bounded) until every expected result has been observed.
  task automatic drain();
    int waited;
    idle();
    waited = 0;
    while ((q[0].size() != 0 || q[1].size() != 0) && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    #3;
    check("drain_empty", 16'(q[0].size() + q[1].size()), 16'd0);
  endtask

  initial begin
    #1;
    check("reset_out_valid", {15'd0, out_valid_m}, 16'd0);
    check("reset_result",    {7'd0, result_m},     16'd0);
    check("reset_flags_err", {11'd0, flags_m, err_m}, 16'd0);
    check("reset_acc",       {8'd0, acc_m},        16'd0);
    #11;
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("in_ready_after_reset", {15'd0, in_ready_m}, 16'd1);

    // Latency: accepted at one edge, visible after the second edge.
    send(1'b0, 3'b000, 8'd200, 8'd100, 9'h12C, 4'b0100, 1'b0);
    idle(); #1;
    check("latency_cycle1", {15'd0, out_valid_m}, 16'd0);
    @(negedge clk); #1;
    check("latency_cycle2", {15'd0, out_valid_m}, 16'd1);

    send(1'b0, 3'b001, 8'd5,   8'd7,   9'h1FE, 4'b0110, 1'b0);
    send(1'b0, 3'b001, 8'h80,  8'h01,  9'h07F, 4'b1000, 1'b0);
    send(1'b0, 3'b010, 8'hF0,  8'h3C,  9'h030, 4'b0000, 1'b0);
    send(1'b0, 3'b011, 8'hF0,  8'h3C,  9'h0FC, 4'b0010, 1'b0);
    send(1'b0, 3'b100, 8'hF0,  8'h3C,  9'h0CC, 4'b0010, 1'b0);
    send(1'b0, 3'b010, 8'h0F,  8'hF0,  9'h000, 4'b0001, 1'b0);
    send(1'b0, 3'b000, 8'h7F,  8'h01,  9'h080, 4'b1010, 1'b0);
    // Back-to-back accumulator chain.
    send(1'b0, 3'b110, 8'h33,  8'h44,  9'h000, 4'b0001, 1'b0);
    send(1'b0, 3'b101, 8'hF0,  8'h00,  9'h0F0, 4'b0010, 1'b0);
    send(1'b0, 3'b101, 8'h20,  8'h00,  9'h110, 4'b0100, 1'b0);
    drain();
    check("acc_after_chain", {8'd0, acc_m}, 16'h0010);

    // Reserved opcode leaves the accumulator alone.
    send(1'b0, 3'b111, 8'h55,  8'h0F,  9'h000, 4'b0000, 1'b1);
    drain();
    check("acc_after_rsvd", {8'd0, acc_m}, 16'h0010);
    send(1'b0, 3'b101, 8'h01,  8'h00,  9'h011, 4'b0000, 1'b0);
    drain();
    check("acc_after_inc", {8'd0, acc_m}, 16'h0011);

    // Stream under a 1,0,0,1 consumer pattern.
    rdy_mode = 1;
    send(1'b0, 3'b000, 8'h01,  8'h02,  9'h003, 4'b0000, 1'b0);
    send(1'b0, 3'b000, 8'h10,  8'h20,  9'h030, 4'b0000, 1'b0);
    send(1'b0, 3'b000, 8'hFF,  8'h01,  9'h100, 4'b0101, 1'b0);
    send(1'b0, 3'b000, 8'h80,  8'h80,  9'h100, 4'b1101, 1'b0);
    send(1'b0, 3'b000, 8'h40,  8'h40,  9'h080, 4'b1010, 1'b0);
    send(1'b0, 3'b000, 8'hAA,  8'h11,  9'h0BB, 4'b0010, 1'b0);
    drain();
    rdy_mode = 0;

    // Saturating instance.
    send(1'b1, 3'b000, 8'd200, 8'd100, 9'h1FF, 4'b0110, 1'b0);
    send(1'b1, 3'b110, 8'h00,  8'h00,  9'h000, 4'b0001, 1'b0);
    send(1'b1, 3'b101, 8'hF0,  8'h00,  9'h0F0, 4'b0010, 1'b0);
    send(1'b1, 3'b101, 8'h20,  8'h00,  9'h1FF, 4'b0110, 1'b0);
    drain();
    check("sat_acc", {8'd0, acc_s}, 16'h00FF);
    send(1'b1, 3'b101, 8'h01,  8'h00,  9'h1FF, 4'b0110, 1'b0);
    send(1'b1, 3'b000, 8'h10,  8'h20,  9'h030, 4'b0000, 1'b0);
    drain();

    // Reset with two operations in flight behind a stalled consumer.
    rdy_mode = 2;
    send(1'b0, 3'b000, 8'h01,  8'h01,  9'h002, 4'b0000, 1'b0);
    send(1'b0, 3'b000, 8'h02,  8'h02,  9'h004, 4'b0000, 1'b0);
    idle();
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", {15'd0, out_valid_m}, 16'd0);
    check("rst_acc",       {8'd0, acc_m},        16'd0);
    check("rst_result",    {7'd0, result_m},     16'd0);
    q[0].delete();
    rdy_mode = 0;
    @(negedge clk);
    #3;
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("in_ready_after_pulse", {15'd0, in_ready_m}, 16'd1);
    repeat (5) @(negedge clk);
    #1;
    check("no_stale_output", {15'd0, out_valid_m}, 16'd0);
    send(1'b0, 3'b101, 8'h05,  8'h00,  9'h005, 4'b0000, 1'b0);
    drain();
    check("acc_after_reset", {8'd0, acc_m}, 16'h0005);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
